// File: rtl/soc_pio_pkg.sv
// Shared definitions for the SoC PIO blocks: register word addresses and edge-capture modes.
// Parameters only; no logic, latency or flow control of its own.
package soc_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_ANY     = 2'd2
  } edge_type_e;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchronizer plus one-cycle-delayed copy and per-bit edge detection.
// sync_in lags in_port by SYNC_STAGES cycles; edge_det is combinational; no flow control.
module pio_sync_edge
  import soc_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_det
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  prev_q, prev_d;
  logic [WIDTH-1:0]                  rise, fall;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  always_comb begin
    rise     = sync_in & ~prev_q;
    fall     = ~sync_in & prev_q;
    edge_det = rise;
    if (EDGE_TYPE == int'(EDGE_FALLING)) begin
      edge_det = fall;
    end else if (EDGE_TYPE == int'(EDGE_ANY)) begin
      edge_det = rise | fall;
    end
  end

endmodule

// File: rtl/avalon_pio_input.sv
// Avalon-MM input PIO: synchronized data, irq mask and W1C edge capture with level irq.
// Reads return one cycle after address (0 wait states); no waitrequest, never stalls.
module avalon_pio_input
  import soc_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync_in, edge_det;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en, mask_wr, cap_clr;
  logic [WIDTH-1:0] clr_bits;
  logic             unused_wdata;

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .sync_in  (sync_in),
    .edge_det (edge_det)
  );

  assign unused_wdata = ^writedata;

  always_comb begin
    wr_en    = chipselect & ~write_n;
    mask_wr  = wr_en && (address == PIO_ADDR_IRQMASK);
    cap_clr  = wr_en && (address == PIO_ADDR_EDGECAP);
    clr_bits = cap_clr ? writedata[WIDTH-1:0] : '0;

    irqmask_d = mask_wr ? writedata[WIDTH-1:0] : irqmask_q;
    // A new edge overrides a same-cycle clear so no event is lost.
    edgecap_d = edge_det | (edgecap_q & ~clr_bits);

    readdata_d = '0;
    case (address)
      PIO_ADDR_DATA:    readdata_d[WIDTH-1:0] = sync_in;
      PIO_ADDR_DIR:     readdata_d = '0;
      PIO_ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
      PIO_ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      default:          readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_avalon_pio_input.sv
// Directed and random checks of two builds (rising-edge and any-edge) against a history-based model.
module tb_avalon_pio_input;

  localparam int W = 8;
  localparam int S = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    address = 2'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = 32'd0;
  logic [W-1:0]  in_port = '0;
  logic [31:0]   rd_r, rd_a;
  logic          irq_r, irq_a;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  avalon_pio_input #(.WIDTH(W), .EDGE_TYPE(0), .SYNC_STAGES(S)) dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_r), .in_port(in_port), .irq(irq_r)
  );

  avalon_pio_input #(.WIDTH(W), .EDGE_TYPE(2), .SYNC_STAGES(S)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a), .in_port(in_port), .irq(irq_a)
  );

  // Model: hist[j] is the in_port value sampled j+1 clock edges ago (since reset).
  logic [W-1:0] hist[$];
  logic [W-1:0] m_mask;
  logic [W-1:0] m_cap [2];
  logic [31:0]  m_rd  [2];
  int           m_et  [2] = '{0, 2};

  function automatic logic [W-1:0] hget(int k);
    if (k < hist.size()) return hist[k];
    return '0;
  endfunction

  function automatic logic [W-1:0] edges_of(int et, logic [W-1:0] cur, logic [W-1:0] old);
    logic [W-1:0] changed;
    changed = cur ^ old;
    if (et == 0) return changed & cur;
    if (et == 1) return changed & old;
    return changed;
  endfunction

  task automatic model_clear();
    hist.delete();
    m_mask = '0;
    for (int k = 0; k < 2; k++) begin
      m_cap[k] = '0;
      m_rd[k]  = '0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    logic [W-1:0] sp, pp, clr;
    logic         wr;
    @(posedge clk);
    if (!reset_n) begin
      model_clear();
    end else begin
      sp  = hget(S - 1);
      pp  = hget(S);
      wr  = chipselect && !write_n;
      clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
      for (int k = 0; k < 2; k++) begin
        case (address)
          2'd0: m_rd[k] = {{(32-W){1'b0}}, sp};
          2'd2: m_rd[k] = {{(32-W){1'b0}}, m_mask};
          2'd3: m_rd[k] = {{(32-W){1'b0}}, m_cap[k]};
          default: m_rd[k] = 32'd0;
        endcase
        m_cap[k] = edges_of(m_et[k], sp, pp) | (m_cap[k] & ~clr);
      end
      if (wr && address == 2'd2) m_mask = writedata[W-1:0];
      hist.push_front(in_port);
      if (hist.size() > S + 1) void'(hist.pop_back());
    end
    #1;
    check("rd_rise",  rd_r, m_rd[0]);
    check("rd_any",   rd_a, m_rd[1]);
    check("irq_rise", {31'd0, irq_r}, {31'd0, |(m_cap[0] & m_mask)});
    check("irq_any",  {31'd0, irq_a}, {31'd0, |(m_cap[1] & m_mask)});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    model_clear();
    // Reset held with inputs high
    in_port = 8'hFF;
    steps(3);
    check("rst_rd", rd_r, 32'd0);
    check("rst_irq", {31'd0, irq_r}, 32'd0);
    reset_n = 1'b1;
    address = 2'd0;
    steps(3);
    check("rel_data", rd_r, 32'h000000FF);
    address = 2'd3;
    step();
    check("rel_cap", rd_r, 32'h000000FF);
    bus_wr(2'd3, 32'hFF);

    // Read latency
    in_port = 8'hA5;
    address = 2'd0;
    steps(4);
    check("lat_data", rd_r, 32'h000000A5);
    address = 2'd1;
    step();
    check("lat_rsvd", rd_r, 32'd0);
    bus_wr(2'd3, 32'hFF);

    // Edge + irq on bit 0
    bus_wr(2'd2, 32'h01);
    in_port = 8'hA4;
    address = 2'd0;
    steps(4);
    bus_wr(2'd3, 32'hFF);
    in_port = 8'hA5;
    address = 2'd3;
    steps(4);
    check("edge_cap", rd_r, 32'h01);
    check("edge_irq", {31'd0, irq_r}, 32'd1);
    bus_wr(2'd3, 32'h01);
    check("clr_irq", {31'd0, irq_r}, 32'd0);

    // Masked edge on bit 3
    in_port = 8'hAD;
    address = 2'd3;
    steps(4);
    check("mask_cap", rd_r, 32'h08);
    check("mask_irq0", {31'd0, irq_r}, 32'd0);
    bus_wr(2'd2, 32'h08);
    check("mask_irq1", {31'd0, irq_r}, 32'd1);
    bus_wr(2'd3, 32'hFF);

    // Set wins over same-cycle clear on bit 2
    in_port = 8'hA9;
    address = 2'd0;
    steps(4);
    bus_wr(2'd3, 32'hFF);
    in_port = 8'hAD;
    steps(2);
    bus_wr(2'd3, 32'h04);
    address = 2'd3;
    step();
    check("setwins", rd_r & 32'h04, 32'h04);
    bus_wr(2'd3, 32'hFF);

    // Any-edge build: bit 5 fall, clear, rise
    in_port = 8'h8D;
    address = 2'd3;
    steps(4);
    check("any_fall", rd_a, 32'h20);
    check("rise_nofall", rd_r, 32'h00);
    bus_wr(2'd3, 32'hFF);
    in_port = 8'hAD;
    address = 2'd3;
    steps(4);
    check("any_rise", rd_a, 32'h20);
    check("rise_rise", rd_r, 32'h20);

    // Writes to data/reserved leave state alone
    bus_wr(2'd0, 32'hFFFFFFFF);
    bus_wr(2'd1, 32'hFFFFFFFF);
    address = 2'd2;
    step();
    check("ro_mask", rd_r, 32'h08);
    address = 2'd3;
    step();
    check("ro_cap", rd_a, 32'h20);

    // Asynchronous reset mid-operation
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    check("arst_rd_r", rd_r, 32'd0);
    check("arst_rd_a", rd_a, 32'd0);
    check("arst_irq", {31'd0, irq_a}, 32'd0);
    steps(2);
    reset_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
      address    = 2'($urandom_range(0, 3));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 2) != 0);
      writedata  = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/avalon_pio_input.md
Name: avalon_pio_input

Overview:
- Avalon-MM slave input PIO: the read-side counterpart of the SoC's output PIO blocks.
- Samples an external WIDTH-bit input bus (buttons/status lines) through a synchronizer and exposes the sampled value to the Nios II.
- Captures edges per bit and raises a level-sensitive irq for edges on unmasked bits.
- Sits on the system interconnect beside the output PIOs; the register map is software-compatible with the standard PIO layout.

Parameters:
- WIDTH, 8, number of input bits (1..32).
- EDGE_TYPE, 0, edge to capture: 0 = rising, 1 = falling, 2 = any.
- SYNC_STAGES, 2, flip-flops in the input synchronizer (>= 2).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, registered.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  interrupt request, active high, level.

Behaviour:
- Reset (async, reset_n=0): all state clears to 0 immediately; this covers sync chain, delayed copy, irqmask, edgecapture and readdata. irq=0. Reset mid-operation discards pending edges; no edge is detected on the first cycle after reset release from a reset-state compare unless the synced value differs from 0.
- Synchronizer: in_port passes through SYNC_STAGES flops to give sync_in. A further flop holds prev_in. in_port to the data register read value takes SYNC_STAGES cycles.
- Edge detect per bit i:
  - rise = sync_in & ~prev_in; fall = ~sync_in & prev_in.
  - edge_det selects rise, fall, or rise|fall according to EDGE_TYPE.
- Register map (word addresses):
  - 0 DATA: read returns sync_in zero-extended; writes ignored.
  - 1 reserved: reads 0; writes ignored.
  - 2 IRQMASK: R/W, bits [WIDTH-1:0]; upper bits read 0.
  - 3 EDGECAPTURE: read returns captured edges; write-1-to-clear per bit.
- Write qualifier: chipselect & ~write_n & address match.
- EDGECAPTURE update per bit: if edge_det[i], set to 1; else if clear_write & writedata[i], clear to 0; else hold.
  - Simultaneous edge and clear on the same bit: set wins, so no edge is lost.
- IRQMASK write takes effect next cycle.
- Read: readdata <= mux(address) every clk, independent of chipselect/read strobe. Read latency is 1 cycle (fixed-latency slave, wait states 0). Unused upper bits are always 0.
- irq = |(edgecapture & irqmask), combinational from registers.
  - irq asserts the cycle after the capturing edge registers.
  - irq deasserts the cycle after the clearing write or the masking write.
- No back-pressure: waitrequest is not generated.

Decomposition:
- Shared package soc_pio_pkg holds:
  - address constants PIO_ADDR_DATA=0, PIO_ADDR_DIR=1, PIO_ADDR_IRQMASK=2, PIO_ADDR_EDGECAP=3.
  - edge-type enum EDGE_RISING/EDGE_FALLING/EDGE_ANY.
- One natural sub-module: pio_sync_edge (synchronizer chain, prev_in and edge_det; parameters WIDTH, SYNC_STAGES, EDGE_TYPE). Register file and read mux stay in the top.

Test Plan:
- Reset: drive in_port=8'hFF with reset_n=0 -> readdata=0 and irq=0 throughout; after release, read addr 0 returns 32'h000000FF after SYNC_STAGES+1 cycles, and edgecapture=8'hFF (rising, from 0).
- Read latency: hold in_port=8'hA5; present address=0 on cycle N -> readdata=32'h000000A5 on cycle N+1; address=1 -> 0.
- Edge + irq: write IRQMASK=8'h01; pulse in_port[0] 0->1 -> edgecapture reads 8'h01, irq=1. Write addr 3 data 8'h01 -> irq=0 the next cycle.
- Masking: edge on bit 3 with mask 8'h01 -> edgecapture=8'h08, irq=0. Write IRQMASK=8'h08 -> irq=1 the next cycle.
- Set-wins collision: time a rising edge on bit 2 to register on the same cycle as a write of 8'h04 to addr 3 -> edgecapture bit 2 remains 1.
- EDGE_TYPE=2 build: in_port[5] toggles 0->1->0 with a clear in between -> each transition sets bit 5. Writes to addr 0/1 leave all state unchanged.
